bus_sram: RTL and testbench

BUS_SRAM -- requirements
Module: bus_sram

---
 rtl/bus_sram.sv | 160 ++++++++++++++++
 tb/tb_bus_sram.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sram.sv
// ---------------------------------------------------------------------------
// BusSram: single-port word-addressed SRAM behind a simple cyc/ack bus.
//
// A request is captured in IDLE. The block then spends WAIT_STATES cycles
// in WAIT and gives a one-cycle ack in ACK. Reads present data in the ack
// cycle and keep it until the next read ack. Writes commit on the clock
// edge that ends the ack cycle. Reset never clears the memory array.
//
// Optional feature (macro BUS_SRAM_ROM_GUARD_EN):
//   A write whose captured address is below ROM_TOP still gets a normal ack,
//   but the memory is left unchanged and the sticky wr_fault flag is set.
//   Only rst clears wr_fault. When the macro is not defined, every write is
//   performed and wr_fault is constant 0.
//
// Ports:
//   clk         single clock; all state changes on its rising edge
//   rst         synchronous active-high reset
//   bus_addr    word address from the master
//   bus_wrdata  write data
//   bus_rddata  read data, valid while bus_ack=1, held until the next read
//   bus_cyc     request valid
//   bus_write   1 = write, 0 = read
//   bus_ack     one-cycle completion pulse
//   wr_fault    sticky flag: a write hit the guarded region
// ---------------------------------------------------------------------------
module bus_sram #(
  parameter int ADDR_WIDTH  = 14,
  parameter int MEM_WIDTH   = 16,
  parameter int WAIT_STATES = 1,
  parameter int ROM_TOP     = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [MEM_WIDTH-1:0]  bus_wrdata,
  output logic [MEM_WIDTH-1:0]  bus_rddata,
  input  logic                  bus_cyc,
  input  logic                  bus_write,
  output logic                  bus_ack,
  output logic                  wr_fault
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  logic [MEM_WIDTH-1:0]  mem_q [2**ADDR_WIDTH];

  state_e                state_q,  state_d;
  logic [3:0]            cnt_q,    cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic                  write_q,  write_d;
  logic [MEM_WIDTH-1:0]  wdata_q,  wdata_d;
  logic [MEM_WIDTH-1:0]  rddata_q;

  logic rd_en;
  logic wr_commit;
  logic wr_blocked;

  // Next-state logic. Requests are captured only in IDLE. ACK always returns
  // to IDLE without looking at bus_cyc. Each request therefore takes
  // 2+WAIT_STATES cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus_cyc) begin
          addr_d  = bus_addr;
          write_d = bus_write;
          wdata_d = bus_wrdata;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        // The counter enters WAIT holding WAIT_STATES. Leaving when it reads
        // 1 gives exactly WAIT_STATES cycles in WAIT.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The read is registered on the edge that enters ACK, so the data is
  // present for the whole ack cycle. addr_d already holds the captured
  // address in both the IDLE->ACK and WAIT->ACK cases.
  assign rd_en     = (state_d == ACK) && (state_q != ACK) && !write_d;
  assign wr_commit = (state_q == ACK) && write_q;

`ifdef BUS_SRAM_ROM_GUARD_EN
  logic fault_q;

  assign wr_blocked = (32'(addr_q) < 32'(ROM_TOP));

  // Sticky fault flag. It is set on the same edge where the blocked write
  // would have committed, so a write aborted by reset raises no fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (wr_commit && wr_blocked) begin
      fault_q <= 1'b1;
    end
  end

  assign wr_fault = fault_q;
`else
  logic unused_rom_top;

  assign unused_rom_top = (ROM_TOP != 0);
  assign wr_blocked     = 1'b0;
  assign wr_fault       = 1'b0;
`endif

  // Control and captured-request registers, plus the read-data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      rddata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      if (rd_en) begin
        rddata_q <= mem_q[addr_d];
      end
    end
  end

  // The memory array has no reset. A write commits only if rst is low on
  // the edge that ends ACK, so a reset during ACK aborts the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_commit && !wr_blocked) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign bus_ack    = (state_q == ACK);
  assign bus_rddata = rddata_q;

endmodule

// File: tb/tb_bus_sram.sv
// ---------------------------------------------------------------------------
// tb_bus_sram: self-checking bench for bus_sram.
// Three instances use WAIT_STATES = 1, 0 and 3, with default widths.
// Expected results come from a sparse reference memory (associative array),
// a fixed latency of 1+WAIT_STATES cycles, and a per-instance fault flag.
// ---------------------------------------------------------------------------
module tb_bus_sram;

  localparam int RomTop = 256;
`ifdef BUS_SRAM_ROM_GUARD_EN
  localparam bit GuardOn = 1'b1;
`else
  localparam bit GuardOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] busAddr   [3];
  logic [15:0] busWrdata [3];
  logic [15:0] busRddata [3];
  logic        busCyc    [3];
  logic        busWrite  [3];
  logic        busAck    [3];
  logic        wrFault   [3];

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state.
  logic [15:0] modelMem [int];
  logic [15:0] lastRd      [3];
  bit          lastRdKnown [3];
  bit          modelFault  [3];

  always #5 clk = ~clk;

  bus_sram #(.WAIT_STATES(1)) dut0 (
    .clk(clk), .rst(rst), .bus_addr(busAddr[0]), .bus_wrdata(busWrdata[0]),
    .bus_rddata(busRddata[0]), .bus_cyc(busCyc[0]), .bus_write(busWrite[0]),
    .bus_ack(busAck[0]), .wr_fault(wrFault[0])
  );

  bus_sram #(.WAIT_STATES(0)) dut1 (
    .clk(clk), .rst(rst), .bus_addr(busAddr[1]), .bus_wrdata(busWrdata[1]),
    .bus_rddata(busRddata[1]), .bus_cyc(busCyc[1]), .bus_write(busWrite[1]),
    .bus_ack(busAck[1]), .wr_fault(wrFault[1])
  );

  bus_sram #(.WAIT_STATES(3)) dut2 (
    .clk(clk), .rst(rst), .bus_addr(busAddr[2]), .bus_wrdata(busWrdata[2]),
    .bus_rddata(busRddata[2]), .bus_cyc(busCyc[2]), .bus_write(busWrite[2]),
    .bus_ack(busAck[2]), .wr_fault(wrFault[2])
  );

  function automatic int wsOf(input int idx);
    case (idx)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int key(input int idx, input logic [13:0] a);
    return idx * 65536 + int'(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One transfer on instance idx. bus_cyc drops right after capture. If
  // scramble is set, the address and data are also changed then.
  task automatic applyStimulus(input int idx, input bit wr, input logic [13:0] a,
                               input logic [15:0] d, input bit scramble,
                               input logic [13:0] scrambleAddr);
    int lat;
    @(negedge clk);
    busCyc[idx]    = 1'b1;
    busWrite[idx]  = wr;
    busAddr[idx]   = a;
    busWrdata[idx] = d;
    @(posedge clk);
    @(negedge clk);
    busCyc[idx] = 1'b0;
    if (scramble) begin
      busAddr[idx]   = scrambleAddr;
      busWrdata[idx] = ~d;
    end
    lat = 1;
    while (busAck[idx] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput($sformatf("latency inst%0d", idx), lat, 1 + wsOf(idx));
    if (!wr) begin
      if (modelMem.exists(key(idx, a))) begin
        checkOutput($sformatf("read data inst%0d addr 0x%0h", idx, a),
                    32'(busRddata[idx]), 32'(modelMem[key(idx, a)]));
        lastRd[idx]      = modelMem[key(idx, a)];
        lastRdKnown[idx] = 1'b1;
      end else begin
        lastRdKnown[idx] = 1'b0;
      end
    end else begin
      if (lastRdKnown[idx]) begin
        checkOutput($sformatf("rddata kept over write inst%0d", idx),
                    32'(busRddata[idx]), 32'(lastRd[idx]));
      end
      if (GuardOn && int'(a) < RomTop) begin
        modelFault[idx] = 1'b1;
      end else begin
        modelMem[key(idx, a)] = d;
      end
    end
    @(negedge clk);
    checkOutput($sformatf("ack one cycle inst%0d", idx), 32'(busAck[idx]), 32'd0);
    checkOutput($sformatf("wr_fault inst%0d", idx), 32'(wrFault[idx]), 32'(modelFault[idx]));
    if (!wr && lastRdKnown[idx]) begin
      checkOutput($sformatf("rddata hold inst%0d", idx),
                  32'(busRddata[idx]), 32'(lastRd[idx]));
    end
  endtask

  initial begin
    bit sawAck;
    logic [13:0] ra;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      busAddr[i]     = '0;
      busWrdata[i]   = '0;
      busCyc[i]      = 1'b0;
      busWrite[i]    = 1'b0;
      lastRd[i]      = 16'h0000;
      lastRdKnown[i] = 1'b1;
      modelFault[i]  = 1'b0;
    end

    // Reset has priority over a request that is already present.
    busCyc[0]  = 1'b1;
    busAddr[0] = 14'h0300;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset ack inst%0d", i), 32'(busAck[i]), 32'd0);
      checkOutput($sformatf("reset rddata inst%0d", i), 32'(busRddata[i]), 32'd0);
      checkOutput($sformatf("reset wr_fault inst%0d", i), 32'(wrFault[i]), 32'd0);
    end
    busCyc[0] = 1'b0;
    rst       = 1'b0;

    // Write 0x1234 to 0x0300 (ack after 2 cycles), then read it back.
    applyStimulus(0, 1'b1, 14'h0300, 16'h1234, 1'b0, 14'h0);
    applyStimulus(0, 1'b0, 14'h0300, 16'h0000, 1'b0, 14'h0);

    // Write 0xBEEF to 0x0010: blocked with the guard built in, stored without it.
    applyStimulus(0, 1'b1, 14'h0010, 16'hBEEF, 1'b0, 14'h0);
    checkOutput("guard fault flag", 32'(wrFault[0]), 32'(GuardOn));
    applyStimulus(0, 1'b0, 14'h0010, 16'h0000, 1'b0, 14'h0);

    // Zero wait states, bus_cyc held high: back-to-back reads.
    applyStimulus(1, 1'b1, 14'h0300, 16'hA5A5, 1'b0, 14'h0);
    applyStimulus(1, 1'b1, 14'h0301, 16'h5A5A, 1'b0, 14'h0);
    @(negedge clk);
    busCyc[1]   = 1'b1;
    busWrite[1] = 1'b0;
    busAddr[1]  = 14'h0300;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b ack 1", 32'(busAck[1]), 32'd1);
    checkOutput("b2b data 1", 32'(busRddata[1]), 32'hA5A5);
    busAddr[1] = 14'h0301;
    @(negedge clk);
    checkOutput("b2b gap", 32'(busAck[1]), 32'd0);
    @(negedge clk);
    checkOutput("b2b ack 2", 32'(busAck[1]), 32'd1);
    checkOutput("b2b data 2", 32'(busRddata[1]), 32'h5A5A);
    busCyc[1] = 1'b0;
    @(negedge clk);
    checkOutput("b2b ack end", 32'(busAck[1]), 32'd0);
    lastRd[1]      = 16'h5A5A;
    lastRdKnown[1] = 1'b1;

    // Three wait states: bus_addr moves to 0 after capture, data must come
    // from the original address.
    applyStimulus(2, 1'b1, 14'h0300, 16'hC0DE, 1'b0, 14'h0);
    applyStimulus(2, 1'b1, 14'h0000, 16'h1111, 1'b0, 14'h0);
    applyStimulus(2, 1'b0, 14'h0300, 16'h0000, 1'b1, 14'h0000);

    // Reset during WAIT aborts a write to 0x0400.
    applyStimulus(2, 1'b1, 14'h0400, 16'h7777, 1'b0, 14'h0);
    @(negedge clk);
    busCyc[2]    = 1'b1;
    busWrite[2]  = 1'b1;
    busAddr[2]   = 14'h0400;
    busWrdata[2] = 16'h9999;
    @(posedge clk);
    @(negedge clk);
    busCyc[2] = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    sawAck = busAck[2];
    repeat (8) begin
      @(negedge clk);
      if (busAck[2] === 1'b1) sawAck = 1'b1;
    end
    checkOutput("aborted ack", 32'(sawAck), 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("post-reset rddata inst%0d", i), 32'(busRddata[i]), 32'd0);
      checkOutput($sformatf("post-reset wr_fault inst%0d", i), 32'(wrFault[i]), 32'd0);
      lastRd[i]      = 16'h0000;
      lastRdKnown[i] = 1'b1;
      modelFault[i]  = 1'b0;
    end
    applyStimulus(2, 1'b0, 14'h0400, 16'h0000, 1'b0, 14'h0);

    // Random reads and writes on every instance, on a small address pool so
    // that reads often hit addresses written earlier.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 30; n++) begin
        if ($urandom_range(0, 3) == 0) begin
          ra = 14'($urandom_range(0, 31));
        end else begin
          ra = 14'h0300 + 14'($urandom_range(0, 15));
        end
        applyStimulus(i, 1'($urandom_range(0, 1)), ra, 16'($urandom),
                      1'($urandom_range(0, 1)), 14'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
